uart_mem_bridge: RTL and testbench

UART-to-memory bus initiator for the MIPS pipeline SoC. It takes bytes from the UART receiver, decodes read and write command frames, and issues single-word accesses on the DataMemory port (RAM and the 0x4000_xxxx peripheral space). Responses go back as bytes through the UART transmitter. It serves as the host-side loader and debug path: while `busy` is high, the top-level mux gives it the memory port instead of the CPU.

---
 rtl/uart_mem_bridge_if.sv | 34 +++
 rtl/uart_mem_bridge.sv | 198 +++++++++++++++++++
 tb/tb_uart_mem_bridge.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_mem_bridge_if.sv
// Bundles the UART byte handshake and the single-word DataMemory port
// driven by the UART-to-memory bridge.
interface uart_mem_bridge_if;
   // UART receiver side
   logic        rx_valid;
   logic [7:0]  rx_data;
   // UART transmitter side
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_done;
   // DataMemory port
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_write;
   logic        mem_read;
   logic        peri_addr;
   logic [31:0] mem_rdata;
   // Tells the top-level mux to hand the memory port to the bridge
   logic        busy;

   // The bridge is the bus initiator.
   modport master (
      input  rx_valid, rx_data, tx_done, mem_rdata,
      output tx_start, tx_data, mem_addr, mem_wdata, mem_write, mem_read,
             peri_addr, busy
   );

   // UART blocks, memory and mux on the other side.
   modport slave (
      output rx_valid, rx_data, tx_done, mem_rdata,
      input  tx_start, tx_data, mem_addr, mem_wdata, mem_write, mem_read,
             peri_addr, busy
   );
endinterface

// File: rtl/uart_mem_bridge.sv
// UART-to-memory bridge: decodes read/write command frames arriving as UART
// bytes, performs one word access on the DataMemory port and answers with
// ACK / NAK / four read-data bytes through the UART transmitter.
module uart_mem_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
   parameter logic [7:0]  CMD_WRITE      = 8'h57,
   parameter logic [7:0]  CMD_READ       = 8'h52,
   parameter logic [7:0]  ACK_BYTE       = 8'h4B,
   parameter logic [7:0]  NAK_BYTE       = 8'h3F
) (
   input  logic              clk,
   input  logic              reset,
   uart_mem_bridge_if.master bus
);

   localparam int unsigned     TO_W     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      IDLE, ADDR, DATA, WR, RD, RD_CAP, SEND, WAIT_TX
   } state_e;

   state_e          state_q,     state_d;
   logic [31:0]     addr_q,      addr_d;       // address being assembled
   logic [23:0]     data_q,      data_d;       // first three data bytes
   logic [23:0]     shift_q,     shift_d;      // read bytes still to send
   logic [31:0]     mem_addr_q,  mem_addr_d;   // held between accesses
   logic [31:0]     mem_wdata_q, mem_wdata_d;
   logic [7:0]      tx_data_q,   tx_data_d;
   logic [1:0]      byte_cnt_q,  byte_cnt_d;   // field byte index 0..3
   logic [2:0]      rem_q,       rem_d;        // response bytes left
   logic            is_write_q,  is_write_d;
   logic            tx_gap_q,    tx_gap_d;     // spacer cycle before next SEND
   logic [TO_W-1:0] to_cnt_q,    to_cnt_d;

   // Register update; reset aborts any frame in flight.
   always_ff @(posedge clk) begin
      // NOTE: registers take non-blocking assignments so every flop samples
      // pre-edge values regardless of statement order.
      if (!reset) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         data_q      <= '0;
         shift_q     <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         tx_data_q   <= '0;
         byte_cnt_q  <= '0;
         rem_q       <= '0;
         is_write_q  <= 1'b0;
         tx_gap_q    <= 1'b0;
         to_cnt_q    <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         shift_q     <= shift_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         tx_data_q   <= tx_data_d;
         byte_cnt_q  <= byte_cnt_d;
         rem_q       <= rem_d;
         is_write_q  <= is_write_d;
         tx_gap_q    <= tx_gap_d;
         to_cnt_q    <= to_cnt_d;
      end
   end

   // Frame decode, access sequencing and response byte sequencing.
   always_comb begin
      // NOTE: every signal gets its hold value first, so no path can leave
      // one unassigned and infer a latch.
      state_d     = state_q;
      addr_d      = addr_q;
      data_d      = data_q;
      shift_d     = shift_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      tx_data_d   = tx_data_q;
      byte_cnt_d  = byte_cnt_q;
      rem_d       = rem_q;
      is_write_d  = is_write_q;
      tx_gap_d    = tx_gap_q;
      to_cnt_d    = to_cnt_q;

      // Inter-byte gap timer: restarts on every byte, saturates at the limit.
      if (bus.rx_valid) begin
         to_cnt_d = '0;
      end else if ((state_q == ADDR || state_q == DATA) && to_cnt_q != TO_LIMIT) begin
         to_cnt_d = to_cnt_q + 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            if (bus.rx_valid) begin
               if (bus.rx_data == CMD_WRITE || bus.rx_data == CMD_READ) begin
                  byte_cnt_d = '0;
                  is_write_d = (bus.rx_data == CMD_WRITE);
                  state_d    = ADDR;
               end else begin
                  tx_data_d = NAK_BYTE;
                  rem_d     = 3'd1;
                  state_d   = SEND;
               end
            end
         end

         ADDR: begin
            if (bus.rx_valid) begin
               addr_d     = {addr_q[23:0], bus.rx_data};
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  if (is_write_q) begin
                     state_d = DATA;
                  end else begin
                     // Word access: the two byte-offset bits are dropped.
                     mem_addr_d = {addr_d[31:2], 2'b00};
                     state_d    = RD;
                  end
               end
            end else if (to_cnt_q == TO_LIMIT) begin
               state_d = IDLE;
            end
         end

         DATA: begin
            if (bus.rx_valid) begin
               data_d     = {data_q[15:0], bus.rx_data};
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  // Address and data are published together so the port
                  // keeps its previous values for the whole frame.
                  mem_addr_d  = {addr_q[31:2], 2'b00};
                  mem_wdata_d = {data_q, bus.rx_data};
                  state_d     = WR;
               end
            end else if (to_cnt_q == TO_LIMIT) begin
               state_d = IDLE;
            end
         end

         WR: begin
            tx_data_d = ACK_BYTE;
            rem_d     = 3'd1;
            state_d   = SEND;
         end

         RD: begin
            state_d = RD_CAP;
         end

         RD_CAP: begin
            tx_data_d = bus.mem_rdata[31:24];
            shift_d   = bus.mem_rdata[23:0];
            rem_d     = 3'd4;
            state_d   = SEND;
         end

         SEND: begin
            tx_gap_d = 1'b0;
            state_d  = WAIT_TX;
         end

         WAIT_TX: begin
            if (tx_gap_q) begin
               // One spacer cycle after tx_done before relaunching.
               tx_gap_d = 1'b0;
               state_d  = SEND;
            end else if (bus.tx_done) begin
               rem_d = rem_q - 3'd1;
               if (rem_q == 3'd1) begin
                  state_d = IDLE;
               end else begin
                  tx_data_d = shift_q[23:16];
                  shift_d   = {shift_q[15:0], 8'h00};
                  tx_gap_d  = 1'b1;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Strobes decode directly from state, so each lasts exactly one cycle
   // and read/write can never overlap.
   assign bus.tx_start  = (state_q == SEND);
   assign bus.mem_write = (state_q == WR);
   assign bus.mem_read  = (state_q == RD);
   assign bus.busy      = (state_q != IDLE);
   assign bus.tx_data   = tx_data_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.peri_addr = (mem_addr_q[31:28] == 4'h4);

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Self-checking bench for uart_mem_bridge: directed frames from the test
// plan plus a randomized write/read mix checked against a word-memory model.
module tb_uart_mem_bridge;

   localparam int unsigned TIMEOUT = 100;
   localparam logic [7:0]  CMD_W   = 8'h57;
   localparam logic [7:0]  CMD_R   = 8'h52;
   localparam logic [7:0]  ACK     = 8'h4B;
   localparam logic [7:0]  NAK     = 8'h3F;

   typedef logic [7:0] bq_t[$];
   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic        peri;
   } wr_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   uart_mem_bridge_if bus();

   uart_mem_bridge #(
      .TIMEOUT_CYCLES(TIMEOUT),
      .CMD_WRITE     (CMD_W),
      .CMD_READ      (CMD_R),
      .ACK_BYTE      (ACK),
      .NAK_BYTE      (NAK)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int unsigned cyc = 0;
   int unsigned last_rx_cyc = 0;

   // Memory seen by the DUT, and the reference view of what it must hold.
   logic [31:0] env_mem [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];

   // Event logs filled by the monitor.
   wr_t         wr_log[$];
   logic [31:0] rd_log[$];
   logic        rd_peri_log[$];
   int unsigned rd_cyc[$];
   int unsigned wr_cyc[$];
   logic [7:0]  tx_log[$];
   int unsigned tx_start_cyc[$];
   int unsigned tx_done_cyc[$];
   int unsigned busy_fall_cyc = 0;
   int          proto_err = 0;
   logic        tx_outstanding = 1'b0;
   logic [7:0]  tx_byte = 8'h00;
   logic        prev_busy = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Memory with registered read data.
   always @(posedge clk) begin
      if (bus.mem_write === 1'b1) env_mem[bus.mem_addr] = bus.mem_wdata;
      bus.mem_rdata <= env_mem.exists(bus.mem_addr) ? env_mem[bus.mem_addr] : 32'h0;
   end

   // UART transmitter: answers every tx_start with a tx_done 2..6 cycles later.
   initial begin
      int unsigned d;
      bus.tx_done = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.tx_start === 1'b1) begin
            d = $urandom_range(2, 6);
            repeat (d) @(posedge clk);
            #1 bus.tx_done = 1'b1;
            @(posedge clk);
            #1 bus.tx_done = 1'b0;
         end
      end
   end

   // Monitor, sampling mid-cycle.
   always @(negedge clk) begin
      if (reset !== 1'b1) begin
         tx_outstanding = 1'b0;
         prev_busy      = 1'b0;
      end else begin
         if (bus.mem_write === 1'b1 && bus.mem_read === 1'b1) proto_err++;
         if (bus.mem_write === 1'b1) begin
            wr_log.push_back('{bus.mem_addr, bus.mem_wdata, bus.peri_addr});
            wr_cyc.push_back(cyc);
         end
         if (bus.mem_read === 1'b1) begin
            rd_log.push_back(bus.mem_addr);
            rd_peri_log.push_back(bus.peri_addr);
            rd_cyc.push_back(cyc);
         end
         if (bus.tx_start === 1'b1) begin
            if (tx_outstanding) proto_err++;
            tx_outstanding = 1'b1;
            tx_byte        = bus.tx_data;
            tx_log.push_back(bus.tx_data);
            tx_start_cyc.push_back(cyc);
         end else if (tx_outstanding && bus.tx_data !== tx_byte) begin
            proto_err++;
         end
         if (bus.tx_done === 1'b1 && tx_outstanding && bus.tx_start !== 1'b1) begin
            tx_outstanding = 1'b0;
            tx_done_cyc.push_back(cyc);
         end
         if (prev_busy === 1'b1 && bus.busy === 1'b0) busy_fall_cyc = cyc;
         prev_busy = bus.busy;
      end
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus helpers ----------------
   function automatic bq_t mk_frame(input logic [7:0] cmd, input logic [31:0] a,
                                    input bit with_data, input logic [31:0] d);
      bq_t q;
      q.push_back(cmd);
      for (int i = 3; i >= 0; i--) q.push_back(a[i*8 +: 8]);
      if (with_data) for (int i = 3; i >= 0; i--) q.push_back(d[i*8 +: 8]);
      return q;
   endfunction

   function automatic bq_t word_bytes(input logic [31:0] w);
      bq_t q;
      for (int i = 3; i >= 0; i--) q.push_back(w[i*8 +: 8]);
      return q;
   endfunction

   task automatic clear_logs();
      wr_log.delete(); wr_cyc.delete();
      rd_log.delete(); rd_peri_log.delete(); rd_cyc.delete();
      tx_log.delete(); tx_start_cyc.delete(); tx_done_cyc.delete();
      proto_err = 0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int unsigned gap);
      @(posedge clk);
      #1;
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      last_rx_cyc  = cyc;
      @(posedge clk);
      #1 bus.rx_valid = 1'b0;
      repeat (gap) @(posedge clk);
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (bus.busy === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic do_frame(input bq_t fr, input int unsigned gap_max, output bit ok);
      foreach (fr[i]) send_byte(fr[i], $urandom_range(0, gap_max));
      wait_idle(400, ok);
      repeat (3) @(posedge clk);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      checks++; if ({bus.tx_start, bus.mem_write, bus.mem_read} !== 3'b000) begin
         failures++; $display("FAIL reset_strobes got=%b exp=000", {bus.tx_start, bus.mem_write, bus.mem_read});
      end
      checks++; if (bus.tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%h exp=00", bus.tx_data); end
      checks++; if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
         failures++; $display("FAIL reset_mem_bus got=%h/%h exp=0/0", bus.mem_addr, bus.mem_wdata);
      end
      @(posedge clk);
      #1 reset = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_write();
      bit ok;
      clear_logs();
      do_frame(mk_frame(CMD_W, 32'h0000_0010, 1'b1, 32'hDEAD_BEEF), 2, ok);
      ref_mem[32'h0000_0010] = 32'hDEAD_BEEF;
      checks++; if (!ok) begin failures++; $display("FAIL write_idle got=busy exp=idle"); end
      checks++; if (wr_log.size() != 1 || rd_log.size() != 0) begin
         failures++; $display("FAIL write_strobes got=wr%0d/rd%0d exp=wr1/rd0", wr_log.size(), rd_log.size());
      end else begin
         checks++; if (wr_log[0].addr !== 32'h0000_0010 || wr_log[0].data !== 32'hDEAD_BEEF || wr_log[0].peri !== 1'b0) begin
            failures++; $display("FAIL write_access got=%h/%h/%b exp=00000010/deadbeef/0",
                                 wr_log[0].addr, wr_log[0].data, wr_log[0].peri);
         end
         checks++; if (wr_cyc[0] != last_rx_cyc + 1) begin
            failures++; $display("FAIL write_latency got=%0d exp=%0d", wr_cyc[0], last_rx_cyc + 1);
         end
      end
      checks++; if (tx_log.size() != 1) begin
         failures++; $display("FAIL write_ack_count got=%0d exp=1", tx_log.size());
      end else begin
         checks++; if (tx_log[0] !== ACK) begin failures++; $display("FAIL write_ack_byte got=%h exp=%h", tx_log[0], ACK); end
         checks++; if (tx_start_cyc[0] != last_rx_cyc + 2) begin
            failures++; $display("FAIL write_ack_latency got=%0d exp=%0d", tx_start_cyc[0], last_rx_cyc + 2);
         end
      end
      checks++; if (tx_done_cyc.size() == 0 || busy_fall_cyc != tx_done_cyc[tx_done_cyc.size()-1] + 1) begin
         failures++; $display("FAIL write_busy_fall got=%0d exp=done+1", busy_fall_cyc);
      end
   endtask

   task automatic test_read();
      bit ok;
      bq_t exp;
      env_mem[32'h4000_000C] = 32'h0000_00A5;
      ref_mem[32'h4000_000C] = 32'h0000_00A5;
      exp = word_bytes(ref_mem[32'h4000_000C]);
      clear_logs();
      do_frame(mk_frame(CMD_R, 32'h4000_000C, 1'b0, 32'h0), 2, ok);
      checks++; if (!ok) begin failures++; $display("FAIL read_idle got=busy exp=idle"); end
      checks++; if (rd_log.size() != 1 || wr_log.size() != 0) begin
         failures++; $display("FAIL read_strobes got=rd%0d/wr%0d exp=rd1/wr0", rd_log.size(), wr_log.size());
      end else begin
         checks++; if (rd_log[0] !== 32'h4000_000C || rd_peri_log[0] !== 1'b1) begin
            failures++; $display("FAIL read_access got=%h/%b exp=4000000c/1", rd_log[0], rd_peri_log[0]);
         end
         checks++; if (rd_cyc[0] != last_rx_cyc + 1) begin
            failures++; $display("FAIL read_latency got=%0d exp=%0d", rd_cyc[0], last_rx_cyc + 1);
         end
      end
      checks++; if (tx_log.size() != 4 || tx_done_cyc.size() != 4) begin
         failures++; $display("FAIL read_byte_count got=%0d exp=4", tx_log.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++; if (tx_log[i] !== exp[i]) begin
               failures++; $display("FAIL read_byte%0d got=%h exp=%h", i, tx_log[i], exp[i]);
            end
         end
         checks++; if (tx_start_cyc[0] != last_rx_cyc + 3) begin
            failures++; $display("FAIL read_first_tx got=%0d exp=%0d", tx_start_cyc[0], last_rx_cyc + 3);
         end
         for (int i = 0; i < 3; i++) begin
            checks++; if (tx_start_cyc[i+1] != tx_done_cyc[i] + 2) begin
               failures++; $display("FAIL read_gap%0d got=%0d exp=%0d", i, tx_start_cyc[i+1], tx_done_cyc[i] + 2);
            end
         end
      end
      checks++; if (proto_err != 0) begin failures++; $display("FAIL read_protocol got=%0d exp=0", proto_err); end
   endtask

   task automatic test_unaligned();
      bit ok;
      bq_t exp;
      exp = word_bytes(ref_mem[32'h0000_0010]);
      clear_logs();
      do_frame(mk_frame(CMD_R, 32'h0000_0013, 1'b0, 32'h0), 1, ok);
      checks++; if (rd_log.size() != 1 || rd_log[0] !== 32'h0000_0010) begin
         failures++; $display("FAIL unaligned_addr got=%h exp=00000010", (rd_log.size() > 0) ? rd_log[0] : 32'hX);
      end
      checks++; if (tx_log.size() != 4 || tx_log[0] !== exp[0] || tx_log[3] !== exp[3]) begin
         failures++; $display("FAIL unaligned_data got=%0d bytes exp=4 starting %h", tx_log.size(), exp[0]);
      end
   endtask

   task automatic test_unknown();
      bit ok;
      clear_logs();
      send_byte(8'h41, 0);
      @(negedge clk);
      checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL unknown_busy_rise got=%b exp=1", bus.busy); end
      wait_idle(100, ok);
      repeat (3) @(posedge clk);
      checks++; if (!ok) begin failures++; $display("FAIL unknown_idle got=busy exp=idle"); end
      checks++; if (tx_log.size() != 1 || tx_log[0] !== NAK) begin
         failures++; $display("FAIL unknown_nak got=%0d bytes exp=1 byte %h", tx_log.size(), NAK);
      end
      checks++; if (wr_log.size() + rd_log.size() != 0) begin
         failures++; $display("FAIL unknown_strobe got=%0d exp=0", wr_log.size() + rd_log.size());
      end
   endtask

   task automatic test_timeout();
      bit ok;
      int unsigned t0;
      logic [31:0] a, d;
      clear_logs();
      send_byte(CMD_W, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      t0 = last_rx_cyc;
      repeat (50) @(posedge clk);
      @(negedge clk);
      checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL timeout_early got=%b exp=1", bus.busy); end
      while (cyc < t0 + TIMEOUT + 8) @(posedge clk);
      @(negedge clk);
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL timeout_busy got=%b exp=0", bus.busy); end
      checks++; if (wr_log.size() + rd_log.size() + tx_log.size() != 0) begin
         failures++; $display("FAIL timeout_activity got=wr%0d/rd%0d/tx%0d exp=0/0/0",
                              wr_log.size(), rd_log.size(), tx_log.size());
      end
      a = {$urandom_range(0, 255), 2'b00} ;
      d = $urandom;
      ref_mem[a] = d;
      clear_logs();
      do_frame(mk_frame(CMD_W, a, 1'b1, d), 2, ok);
      checks++; if (!ok || wr_log.size() != 1 || wr_log[0].addr !== a || wr_log[0].data !== d) begin
         failures++; $display("FAIL timeout_recover got=%0d writes exp=1 at %h", wr_log.size(), a);
      end
      checks++; if (tx_log.size() != 1 || tx_log[0] !== ACK) begin
         failures++; $display("FAIL timeout_recover_ack got=%0d bytes exp=ack", tx_log.size());
      end
   endtask

   task automatic test_random();
      logic [31:0] pool [4];
      pool[0] = 32'h0000_0100; pool[1] = 32'h0000_0FFC;
      pool[2] = 32'h4000_0010; pool[3] = 32'h1234_5678;
      for (int n = 0; n < 14; n++) begin
         logic [31:0] a, wa, d;
         bit          is_wr, ok;
         bq_t         exp;
         a     = pool[$urandom_range(0, 3)] + 32'($urandom_range(0, 3));
         wa    = {a[31:2], 2'b00};
         is_wr = 1'($urandom_range(0, 1));
         d     = $urandom;
         if (is_wr) begin
            ref_mem[wa] = d;
            exp.push_back(ACK);
         end else begin
            exp = word_bytes(ref_mem.exists(wa) ? ref_mem[wa] : 32'h0);
         end
         clear_logs();
         do_frame(mk_frame(is_wr ? CMD_W : CMD_R, a, is_wr, d), 3, ok);
         checks++; if (!ok) begin failures++; $display("FAIL rand%0d_idle got=busy exp=idle", n); end
         checks++; if (wr_log.size() != (is_wr ? 1 : 0) || rd_log.size() != (is_wr ? 0 : 1)) begin
            failures++; $display("FAIL rand%0d_strobes got=wr%0d/rd%0d exp_write=%0b", n, wr_log.size(), rd_log.size(), is_wr);
         end else if (is_wr) begin
            checks++; if (wr_log[0].addr !== wa || wr_log[0].data !== d || wr_log[0].peri !== (wa[31:28] == 4'h4)) begin
               failures++; $display("FAIL rand%0d_write got=%h/%h exp=%h/%h", n, wr_log[0].addr, wr_log[0].data, wa, d);
            end
         end else begin
            checks++; if (rd_log[0] !== wa || rd_peri_log[0] !== (wa[31:28] == 4'h4)) begin
               failures++; $display("FAIL rand%0d_read got=%h exp=%h", n, rd_log[0], wa);
            end
         end
         checks++; if (tx_log.size() != exp.size()) begin
            failures++; $display("FAIL rand%0d_tx_count got=%0d exp=%0d", n, tx_log.size(), exp.size());
         end else begin
            foreach (exp[i]) begin
               checks++; if (tx_log[i] !== exp[i]) begin
                  failures++; $display("FAIL rand%0d_tx%0d got=%h exp=%h", n, i, tx_log[i], exp[i]);
               end
            end
         end
         checks++; if (proto_err != 0) begin failures++; $display("FAIL rand%0d_protocol got=%0d exp=0", n, proto_err); end
      end
   endtask

   task automatic test_reset_wait_tx();
      logic [31:0] val;
      bq_t         fr, exp;
      bit          seen;
      val = 32'hC35A_817E;
      env_mem[32'h0000_0200] = val;
      ref_mem[32'h0000_0200] = val;
      exp = word_bytes(val);
      clear_logs();
      fr = mk_frame(CMD_R, 32'h0000_0200, 1'b0, 32'h0);
      foreach (fr[i]) send_byte(fr[i], 1);
      for (int k = 0; k < 3; k++) begin
         seen = 1'b0;
         for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (bus.tx_start === 1'b1) seen = 1'b1;
         end
         checks++; if (!seen) begin failures++; $display("FAIL rst_tx_start%0d got=none exp=pulse", k); end
         if (k < 2) begin
            // Junk command byte while the bridge sits in SEND.
            bus.rx_valid = 1'b1;
            bus.rx_data  = CMD_W;
            @(posedge clk);
            #1 bus.rx_valid = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      checks++; if (bus.busy !== 1'b1 || bus.tx_start !== 1'b0) begin
         failures++; $display("FAIL rst_in_wait_tx got=busy%b/start%b exp=1/0", bus.busy, bus.tx_start);
      end
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++; if ({bus.busy, bus.tx_start, bus.mem_write, bus.mem_read, bus.peri_addr} !== 5'b0) begin
         failures++; $display("FAIL rst_flags got=%b exp=00000", {bus.busy, bus.tx_start, bus.mem_write, bus.mem_read, bus.peri_addr});
      end
      checks++; if (bus.tx_data !== 8'h00 || bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
         failures++; $display("FAIL rst_values got=%h/%h/%h exp=0/0/0", bus.tx_data, bus.mem_addr, bus.mem_wdata);
      end
      @(posedge clk);
      #1 reset = 1'b1;
      repeat (30) @(posedge clk);
      @(negedge clk);
      checks++; if (tx_log.size() != 3) begin
         failures++; $display("FAIL rst_no_more_tx got=%0d exp=3", tx_log.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++; if (tx_log[i] !== exp[i]) begin
               failures++; $display("FAIL rst_byte%0d got=%h exp=%h", i, tx_log[i], exp[i]);
            end
         end
      end
      checks++; if (wr_log.size() != 0 || rd_log.size() != 1 || bus.busy !== 1'b0) begin
         failures++; $display("FAIL rst_junk_ignored got=wr%0d/rd%0d/busy%b exp=0/1/0", wr_log.size(), rd_log.size(), bus.busy);
      end
   endtask

   initial begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      test_reset();
      test_write();
      test_read();
      test_unaligned();
      test_unknown();
      test_timeout();
      test_random();
      test_reset_wait_tx();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
